// File: rtl/core_ctrl_fsm_pkg.sv
// core_ctrl_fsm_pkg: shared encodings for the RV32I multi-cycle control sequencer.
//   - OP_*    : 7-bit major opcodes (instr[6:0]) recognised by the decoder
//   - state_t : sequencer state encoding, also exported on state_o
//   - PCSEL_* : PC source mux select
//   - WBSEL_* : register-file writeback mux select
//   - op_known(): 1 for opcodes the sequencer executes (ECALL/EBREAK excluded)
package core_ctrl_fsm_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b000_0011;
  localparam logic [6:0] OP_MEM    = 7'b000_1111;  // FENCE
  localparam logic [6:0] OP_IMM    = 7'b001_0011;
  localparam logic [6:0] OP_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OP_STORE  = 7'b010_0011;
  localparam logic [6:0] OP_OP     = 7'b011_0011;
  localparam logic [6:0] OP_LUI    = 7'b011_0111;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;
  localparam logic [6:0] OP_JALR   = 7'b110_0111;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_SYS    = 7'b111_0011;  // ECALL/EBREAK

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_t;

  localparam logic [1:0] PCSEL_PC4 = 2'd0;  // pc + 4
  localparam logic [1:0] PCSEL_IMM = 2'd1;  // pc + imm
  localparam logic [1:0] PCSEL_ALU = 2'd2;  // alu result & ~1

  localparam logic [1:0] WBSEL_ALU  = 2'd0;
  localparam logic [1:0] WBSEL_LOAD = 2'd1;
  localparam logic [1:0] WBSEL_PC4  = 2'd2;
  localparam logic [1:0] WBSEL_IMM  = 2'd3;

  // System opcodes are deliberately "unknown" here: they trap from DECODE.
  function automatic logic op_known(input logic [6:0] op);
    logic known;
    known = 1'b0;
    case (op)
      OP_LOAD, OP_MEM, OP_IMM, OP_AUIPC, OP_STORE,
      OP_OP, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: known = 1'b1;
      OP_SYS:                                    known = 1'b0;
      default:                                   known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/core_ctrl_fsm_mem_wait_timer.sv
// core_ctrl_fsm_mem_wait_timer: wait-state counter with timeout, shared by the
// fetch and data-memory phases of the sequencer.
// Ports:
//   clk, rst_n  in  clock, asynchronous active-low reset
//   req         in  a memory request is outstanding this cycle
//   ready       in  the addressed memory completes this cycle
//   timeout     out request has waited WAIT_MAX cycles with no ready (combinational)
// The counter returns to zero whenever no request is waiting, so every FETCH or
// MEM entry starts from zero. timeout fires in the WAIT_MAX-th waiting cycle;
// ready in that same cycle suppresses it. WAIT_MAX must be >= 1.
module core_ctrl_fsm_mem_wait_timer #(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ready,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_MAX - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             waiting;

  assign waiting = req && !ready;
  assign timeout = waiting && (cnt_q == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (waiting) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle control sequencer for the RV32I core.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB using the opcode of
// the latched IR and drives the datapath strobes and mux selects.
// Ports:
//   clk, rst_n          in   clock, asynchronous active-low reset
//   opcode[6:0]         in   instr[6:0] of the latched IR
//   branch_taken        in   ALU compare result, valid in EXEC
//   imem_req/imem_ready out/in  instruction fetch handshake
//   ir_we               out  latch instruction register
//   dmem_req/dmem_ready out/in  data memory handshake, dmem_we 1=store
//   rf_we, pc_we        out  register-file / PC write strobes
//   pc_sel[1:0]         out  PCSEL_* encoding
//   wb_sel[1:0]         out  WBSEL_* encoding
//   halted              out  high in TRAP (left only by reset)
//   state_o[2:0]        out  current state for debug
//   cycle_cnt, instret_cnt [31:0] out  only when CORE_PERF_CNT_EN is defined
// Handshake: a request is raised by the sequencer and held until the first
// clock edge at which the matching ready is sampled high; that edge completes
// the transfer. A ready seen while its request is low is ignored.
// All strobes are forced low while rst_n is low so an in-flight request drops
// asynchronously with reset.
module core_ctrl_fsm
  import core_ctrl_fsm_pkg::*;
#(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       ir_we,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       rf_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic [1:0] wb_sel,
  output logic       halted,
  output logic [2:0] state_o
`ifdef CORE_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  state_t state_q, state_d;

  logic imem_req_c, ir_we_c, dmem_req_c, dmem_we_c, rf_we_c, pc_we_c;
  logic tmr_req, tmr_ready, timeout;

  // One timer serves both phases; only the ready of the active phase counts.
  assign tmr_req   = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign tmr_ready = (state_q == ST_FETCH) ? imem_ready : dmem_ready;

  core_ctrl_fsm_mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (tmr_req),
    .ready   (tmr_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    imem_req_c = 1'b0;
    ir_we_c    = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    rf_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    pc_sel     = PCSEL_PC4;
    wb_sel     = WBSEL_ALU;
    halted     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_we_c = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_TRAP;
        end
      end

      ST_DECODE: begin
        state_d = op_known(opcode) ? ST_EXEC : ST_TRAP;
      end

      ST_EXEC: begin
        case (opcode)
          OP_BRANCH: begin
            pc_we_c = 1'b1;
            pc_sel  = branch_taken ? PCSEL_IMM : PCSEL_PC4;
            state_d = ST_FETCH;
          end
          OP_MEM: begin
            pc_we_c = 1'b1;
            state_d = ST_FETCH;
          end
          OP_LOAD, OP_STORE: state_d = ST_MEM;
          OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: state_d = ST_WB;
          default: state_d = ST_TRAP;  // opcode changed under us
        endcase
      end

      ST_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (opcode == OP_STORE);
        if (dmem_ready) begin
          if (opcode == OP_STORE) begin
            pc_we_c = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout) begin
          state_d = ST_TRAP;
        end
      end

      ST_WB: begin
        rf_we_c = 1'b1;
        pc_we_c = 1'b1;
        case (opcode)
          OP_LOAD:         wb_sel = WBSEL_LOAD;
          OP_JAL, OP_JALR: wb_sel = WBSEL_PC4;
          OP_LUI:          wb_sel = WBSEL_IMM;
          default:         wb_sel = WBSEL_ALU;
        endcase
        case (opcode)
          OP_JAL:  pc_sel = PCSEL_IMM;
          OP_JALR: pc_sel = PCSEL_ALU;
          default: pc_sel = PCSEL_PC4;
        endcase
        state_d = ST_FETCH;
      end

      ST_TRAP: begin
        halted = 1'b1;
      end

      default: begin
        state_d = ST_TRAP;
      end
    endcase
  end

  // Reset gating on the strobes only; selects and halted are don't-care or
  // already low in the reset state.
  always_comb begin
    imem_req = imem_req_c & rst_n;
    ir_we    = ir_we_c    & rst_n;
    dmem_req = dmem_req_c & rst_n;
    dmem_we  = dmem_we_c  & rst_n;
    rf_we    = rf_we_c    & rst_n;
    pc_we    = pc_we_c    & rst_n;
  end

  assign state_o = state_q;

`ifdef CORE_PERF_CNT_EN
  // Retired instructions are counted on PC update; both counters wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_q != ST_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_we)              instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule
